// File: rtl/logic_pipe2.sv
// logic_pipe2: two-stage registered bitwise-logic pipeline with valid/ready on both sides.
// Optional LOGIC_PIPE2_PARITY_EN adds a registered even-parity output y_par alongside y.
module logic_pipe2 #(
    parameter int WIDTH  = 8,
    parameter bit INV_S2 = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_PIPE2_PARITY_EN
    ,
    output logic             y_par
`endif
);

    logic             s1_v;
    logic [WIDTH-1:0] s1_d;
    logic             s2_v;
    logic [WIDTH-1:0] s2_d;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] s2_next;
    logic             s2_adv;
    logic             in_fire;
    logic             out_fire;

    assign s2_adv   = ~s2_v | out_ready;
    assign in_ready = ~s1_v | s2_adv;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = s2_v & out_ready;

    always_comb begin
        op_res = '0;
        case (op)
            2'b00:   op_res = (a & b) ^ (a | b);
            2'b01:   op_res = a & b;
            2'b10:   op_res = a | b;
            default: op_res = ~(a & b);
        endcase
    end

    assign s2_next = INV_S2 ? ~s1_d : s1_d;

    // s1 empties when it hands its beat to s2 and nothing new arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_d <= '0;
        end else if (in_fire) begin
            s1_v <= 1'b1;
            s1_d <= op_res;
        end else if (s2_adv) begin
            s1_v <= 1'b0;
        end
    end

    // data only moves with a real beat, so y keeps its last value while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            s2_d <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_d <= s2_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_fire) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

    assign out_valid = s2_v;
    assign y         = s2_d;

`ifdef LOGIC_PIPE2_PARITY_EN
    logic s2_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_par <= 1'b0;
        end else if (s2_adv && s1_v) begin
            s2_par <= ^s2_next;
        end
    end

    assign y_par = s2_par;
`else
    // parity output not present in this build
`endif

endmodule

// File: tb/tb_logic_pipe2.sv
// tb_logic_pipe2: scoreboard bench for logic_pipe2, one pass-through and one inverting instance.
// Both instances share the same stimulus; expected raw operator results are queued at acceptance.
module tb_logic_pipe2;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = '0;

    logic         p_in_ready, p_out_valid;
    logic [W-1:0] p_y;
    logic [15:0]  p_cnt;
    logic         i_in_ready, i_out_valid;
    logic [W-1:0] i_y;
    logic [3:0]   i_cnt;
`ifdef LOGIC_PIPE2_PARITY_EN
    logic         p_par, i_par;
`endif

    logic_pipe2 #(.WIDTH(W), .INV_S2(1'b0), .CNT_W(16)) u_pass (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p_in_ready),
        .a(a), .b(b), .op(op), .out_valid(p_out_valid), .out_ready(out_ready),
        .y(p_y), .done_cnt(p_cnt)
`ifdef LOGIC_PIPE2_PARITY_EN
        , .y_par(p_par)
`endif
    );

    logic_pipe2 #(.WIDTH(W), .INV_S2(1'b1), .CNT_W(4)) u_inv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i_in_ready),
        .a(a), .b(b), .op(op), .out_valid(i_out_valid), .out_ready(out_ready),
        .y(i_y), .done_cnt(i_cnt)
`ifdef LOGIC_PIPE2_PARITY_EN
        , .y_par(i_par)
`endif
    );

    int total = 0;
    int bad = 0;
    int accepted = 0;
    int n_out = 0;
    logic [W-1:0] q[$];
    logic         hold_f = 1'b0;
    logic [W-1:0] hold_y = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // scoreboard monitor: pops one expected beat per output transfer
    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_cnt16", {16'h0, p_cnt}, {16'h0, n_out[15:0]});
            chk("done_cnt4", {28'h0, i_cnt}, {28'h0, n_out[3:0]});
            if (hold_f) begin
                chk("stall_valid", {31'h0, p_out_valid}, 32'd1);
                chk("stall_y", {24'h0, p_y}, {24'h0, hold_y});
            end
            if (p_out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail("unexpected_beat");
                end else begin
                    logic [W-1:0] raw;
                    raw = q.pop_front();
                    chk("y_pass", {24'h0, p_y}, {24'h0, raw});
                    chk("y_inv", {24'h0, i_y}, {24'h0, ~raw});
                    chk("valid_inv", {31'h0, i_out_valid}, 32'd1);
`ifdef LOGIC_PIPE2_PARITY_EN
                    chk("par_pass", {31'h0, p_par}, {31'h0, ^raw});
                    chk("par_inv", {31'h0, i_par}, {31'h0, ^(~raw)});
`endif
                end
                n_out++;
                hold_f = 1'b0;
            end else if (p_out_valid) begin
                hold_f = 1'b1;
                hold_y = p_y;
            end else begin
                hold_f = 1'b0;
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [1:0] top, input logic [W-1:0] raw, output int waits);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        op = top;
        waits = 0;
        forever begin
            @(negedge clk);
            if (p_in_ready) begin
                q.push_back(raw);
                accepted++;
                break;
            end
            waits++;
            if (waits > 200) begin
                fail("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        chk("drain_empty", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    int w;
    int a0, n0;

    initial begin
        // reset held with random inputs
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            a = W'($urandom);
            b = W'($urandom);
            op = 2'($urandom);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
        end
        chk("rst_in_ready", {31'h0, p_in_ready}, 32'd1);
        chk("rst_out_valid", {31'h0, p_out_valid}, 32'd0);
        chk("rst_y", {24'h0, p_y}, 32'd0);
        chk("rst_cnt", {16'h0, p_cnt}, 32'd0);
        chk("rst_y_inv", {24'h0, i_y}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // first beat, inverting instance expects 8'h33
        send(8'hF0, 8'h3C, 2'b00, 8'hCC, w);
        @(posedge clk);
        #1;
        chk("first_valid", {31'h0, i_out_valid}, 32'd1);
        chk("first_y_inv", {24'h0, i_y}, 32'h33);
        drain();

        // operator sweep back to back
        send(8'hAA, 8'h0F, 2'b00, 8'hA5, w);
        send(8'hAA, 8'h0F, 2'b01, 8'h0A, w);
        send(8'hAA, 8'h0F, 2'b10, 8'hAF, w);
        send(8'hAA, 8'h0F, 2'b11, 8'hF5, w);
        drain();
        chk("sweep_cnt", {16'h0, p_cnt}, 32'd5);

        // backpressure: five beats, only two fit
        out_ready = 1'b0;
        a0 = accepted;
        fork
            begin
                int lw;
                send(8'h10, 8'h01, 2'b10, 8'h11, lw);
                send(8'h20, 8'h02, 2'b10, 8'h22, lw);
                send(8'h30, 8'h03, 2'b10, 8'h33, lw);
                send(8'h40, 8'h04, 2'b10, 8'h44, lw);
                send(8'h50, 8'h05, 2'b10, 8'h55, lw);
            end
        join_none
        repeat (6) @(posedge clk);
        #1;
        chk("bp_accepts", accepted - a0, 32'd2);
        chk("bp_in_ready", {31'h0, p_in_ready}, 32'd0);
        out_ready = 1'b1;
        wait fork;
        drain();

        // both stages full, simultaneous in/out for 10 cycles
        out_ready = 1'b0;
        send(8'h60, 8'h06, 2'b10, 8'h66, w);
        send(8'h70, 8'h07, 2'b10, 8'h77, w);
        out_ready = 1'b1;
        a0 = accepted;
        n0 = n_out;
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] v;
            v = 8'h80 + 8'(i);
            send(v, v, 2'b01, v, w);
            chk("full_tput_wait", w, 32'd0);
        end
        chk("sim_accepted", accepted - a0, 32'd10);
        chk("sim_emitted", n_out - n0, 32'd10);
        drain();

        // async reset with both stages full
        out_ready = 1'b0;
        send(8'h08, 8'h80, 2'b10, 8'h88, w);
        send(8'h09, 8'h90, 2'b10, 8'h99, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, p_out_valid}, 32'd0);
        chk("mid_rst_valid_inv", {31'h0, i_out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'h0, p_in_ready}, 32'd1);
        chk("mid_rst_y", {24'h0, p_y}, 32'd0);
        chk("mid_rst_cnt", {16'h0, p_cnt}, 32'd0);
        q.delete();
        n_out = 0;
        hold_f = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale", {31'h0, p_out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            logic [W-1:0] v;
            v = 8'(i);
            send(v, 8'h00, 2'b10, v, w);
        end
        drain();
        chk("wrap_cnt4", {28'h0, i_cnt}, 32'd1);
        chk("wrap_cnt16", {16'h0, p_cnt}, 32'd17);

        send(8'h07, 8'h00, 2'b10, 8'h07, w);
        @(posedge clk);
        #1;
        chk("par_beat_y", {24'h0, p_y}, 32'h07);
`ifdef LOGIC_PIPE2_PARITY_EN
        chk("y_par_07", {31'h0, p_par}, 32'd1);
        chk("y_par_f8", {31'h0, i_par}, 32'd1);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
